// File: rtl/pixel_scan_controller.sv
// Pixel scan controller: walks one image frame in raster order, presents
// centered signed coordinates to the delta lookup, registers the returned
// per-microphone delays and hands them downstream over valid/ready.
module pixel_scan_controller #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int NMIC = 16,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS),
  parameter int IW   = $clog2(COLS*ROWS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic signed [XW-1:0] o_p_x,
  output logic signed [YW-1:0] o_p_y,
  input  logic [NMIC*8-1:0]    i_delta,
  output logic [NMIC*8-1:0]    o_delta,
  output logic [IW-1:0]        o_pix_idx,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam logic signed [XW-1:0] X_MIN = XW'(-(COLS/2));
  localparam logic signed [XW-1:0] X_MAX = XW'(COLS/2 - 1);
  localparam logic signed [YW-1:0] Y_MIN = YW'(-(ROWS/2));
  localparam logic [IW-1:0]        LAST  = IW'(COLS*ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          load;

  // A new pixel is captured whenever the output slot is empty or being emptied.
  assign load   = (state == SCAN) && (!o_valid || i_ready);
  assign o_busy = (state != IDLE);

  // Scan FSM, coordinate/index counters and the registered output beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_p_x        <= X_MIN;
      o_p_y        <= Y_MIN;
      idx          <= '0;
      o_pix_idx    <= '0;
      o_delta      <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else if (i_abort) begin
      state        <= IDLE;
      o_p_x        <= X_MIN;
      o_p_y        <= Y_MIN;
      idx          <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) state <= SCAN;
        end
        SCAN: begin
          if (load) begin
            o_delta   <= i_delta;
            o_pix_idx <= idx;
            o_valid   <= 1'b1;
            if (idx == LAST) begin
              o_p_x <= X_MIN;
              o_p_y <= Y_MIN;
              idx   <= '0;
              state <= DRAIN;
            end else begin
              idx <= idx + IW'(1);
              if (o_p_x == X_MAX) begin
                o_p_x <= X_MIN;
                o_p_y <= o_p_y + YW'(1);
              end else begin
                o_p_x <= o_p_x + XW'(1);
              end
            end
          end
        end
        DRAIN: begin
          // The final beat is already loaded; only its handshake remains.
          if (o_valid && i_ready) begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Bench for pixel_scan_controller: a stand-in delta generator drives i_delta
// from the presented coordinates; every beat is checked against the pixel
// expected from its position in the raster sequence.
module tb_pixel_scan_controller;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int NMIC = 16;
  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);
  localparam int IW   = $clog2(COLS*ROWS);
  localparam int NPIX = COLS*ROWS;
  localparam int TIMEOUT = 20000;
  localparam logic signed [XW-1:0] X_MIN = -(COLS/2);
  localparam logic signed [YW-1:0] Y_MIN = -(ROWS/2);

  logic                 clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_start = 1'b0;
  logic                 i_abort = 1'b0;
  logic                 i_ready = 1'b1;
  logic signed [XW-1:0] p_x;
  logic signed [YW-1:0] p_y;
  logic [NMIC*8-1:0]    i_delta;
  logic [NMIC*8-1:0]    o_delta;
  logic [IW-1:0]        o_pix_idx;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_scan_controller #(.COLS(COLS), .ROWS(ROWS), .NMIC(NMIC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .o_p_x(p_x), .o_p_y(p_y), .i_delta(i_delta), .o_delta(o_delta),
    .o_pix_idx(o_pix_idx), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    for (int b = 7; b >= 0; b--)
      if ((r | (1 << b)) * (r | (1 << b)) <= v) r = r | (1 << b);
    return r;
  endfunction

  function automatic int mic_x(input int i);
    if (i == 0) return 120;
    if (i == 5) return 40;
    return (i % 4) * 60 - 90;
  endfunction

  function automatic int mic_y(input int i);
    if (i == 0) return 120;
    if (i == 5) return 40;
    return (i / 4) * 60 - 90;
  endfunction

  // Geometric delay lanes 0..13; lanes 14/15 carry the coordinates themselves.
  function automatic logic [NMIC*8-1:0] gen_delta(input int x, input int y);
    logic [NMIC*8-1:0] d;
    int dx, dy, r2;
    d = '0;
    for (int i = 0; i < 14; i++) begin
      dx = x - mic_x(i);
      dy = y - mic_y(i);
      r2 = dx*dx + dy*dy;
      d[i*8 +: 8] = 8'(isqrt((r2 + 617600) * 35 / 1000));
    end
    d[14*8 +: 8] = 8'(x + 128);
    d[15*8 +: 8] = 8'(y + 128);
    return d;
  endfunction

  always_comb i_delta = gen_delta(int'(p_x), int'(p_y));

  task automatic run_frame(input int stall_at, input int stall_len, input bit rnd_ready,
                           input int abort_at, input int rst_at, input bit busy_starts,
                           output int done_cyc);
    int exp_k, cyc, stalled, ex, ey, bx, by;
    bit fin, known;
    exp_k = 0; cyc = 0; stalled = 0; fin = 0; done_cyc = -1;
    i_ready = 1'b1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 1;
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0 || p_x !== X_MIN || p_y !== Y_MIN) begin
      errors++;
      $display("FAIL start_state busy=%b valid=%b x=%0d y=%0d required busy=1 valid=0 x=%0d y=%0d",
               o_busy, o_valid, p_x, p_y, X_MIN, Y_MIN);
    end
    while (!fin) begin
      if (o_frame_done === 1'b1) begin
        done_cyc = cyc;
        checks++;
        if (exp_k != NPIX || o_busy !== 1'b0 || o_valid !== 1'b0) begin
          errors++;
          $display("FAIL frame_done beats=%0d busy=%b valid=%b required beats=%0d busy=0 valid=0",
                   exp_k, o_busy, o_valid, NPIX);
        end
        @(posedge clk); #1;
        checks++;
        if (o_frame_done !== 1'b0 || o_busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse frame_done=%b busy=%b required 0 0", o_frame_done, o_busy);
        end
        fin = 1;
      end else if (cyc > TIMEOUT) begin
        errors++;
        checks++;
        $display("FAIL timeout beats=%0d required %0d within %0d cycles", exp_k, NPIX, TIMEOUT);
        fin = 1;
      end else begin
        if (o_valid === 1'b1) begin
          checks++;
          if (o_pix_idx !== IW'(exp_k) ||
              o_delta !== gen_delta(exp_k % COLS - COLS/2, exp_k / COLS - ROWS/2)) begin
            errors++;
            $display("FAIL beat idx=%0d delta=%h required idx=%0d delta=%h", o_pix_idx, o_delta,
                     exp_k, gen_delta(exp_k % COLS - COLS/2, exp_k / COLS - ROWS/2));
          end
          known = 1;
          case (exp_k)
            0:       begin ex = -40; ey = -30; end
            79:      begin ex =  39; ey = -30; end
            80:      begin ex = -40; ey = -29; end
            4720:    begin ex = -40; ey =  29; end
            4799:    begin ex =  39; ey =  29; end
            default: begin known = 0; ex = 0; ey = 0; end
          endcase
          if (known) begin
            bx = int'(o_delta[14*8 +: 8]) - 128;
            by = int'(o_delta[15*8 +: 8]) - 128;
            checks++;
            if (bx != ex || by != ey) begin
              errors++;
              $display("FAIL beat_coord idx=%0d at (%0d,%0d) required (%0d,%0d)", exp_k, bx, by, ex, ey);
            end
          end
          if (exp_k == 2440) begin
            checks++;
            if (o_delta[7:0] !== 8'd150 || o_delta[47:40] !== 8'd147) begin
              errors++;
              $display("FAIL center_delta lane0=%0d lane5=%0d required 150 147",
                       o_delta[7:0], o_delta[47:40]);
            end
          end
        end
        i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (o_valid === 1'b1 && exp_k == stall_at && stalled < stall_len) begin
          i_ready = 1'b0;
          stalled++;
        end
        i_start = busy_starts && (cyc == 50 || (o_valid === 1'b1 && exp_k == NPIX-1));
        if (o_valid === 1'b1 && exp_k == abort_at) begin
          i_abort = 1'b1;
          @(posedge clk); #1;
          i_abort = 1'b0;
          checks++;
          if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0 ||
              p_x !== X_MIN || p_y !== Y_MIN) begin
            errors++;
            $display("FAIL abort valid=%b busy=%b done=%b x=%0d y=%0d required 0 0 0 %0d %0d",
                     o_valid, o_busy, o_frame_done, p_x, p_y, X_MIN, Y_MIN);
          end
          @(posedge clk); #1;
          checks++;
          if (o_frame_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle done=%b busy=%b required 0 0", o_frame_done, o_busy);
          end
          fin = 1;
        end else if (o_valid === 1'b1 && exp_k == rst_at) begin
          i_rst = 1'b1;
          @(posedge clk); #1;
          i_rst = 1'b0;
          checks++;
          if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0 || o_pix_idx !== '0 ||
              o_delta !== '0 || p_x !== X_MIN || p_y !== Y_MIN) begin
            errors++;
            $display("FAIL midframe_reset valid=%b busy=%b done=%b idx=%0d delta=%h x=%0d y=%0d required reset values",
                     o_valid, o_busy, o_frame_done, o_pix_idx, o_delta, p_x, p_y);
          end
          fin = 1;
        end else begin
          if (o_valid === 1'b1 && i_ready) exp_k++;
          @(posedge clk); #1;
          cyc++;
          i_start = 1'b0;
        end
      end
    end
    i_ready = 1'b1;
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0 || o_pix_idx !== '0 ||
        o_delta !== '0 || p_x !== X_MIN || p_y !== Y_MIN) begin
      errors++;
      $display("FAIL reset valid=%b busy=%b done=%b idx=%0d delta=%h x=%0d y=%0d required reset values",
               o_valid, o_busy, o_frame_done, o_pix_idx, o_delta, p_x, p_y);
    end
  endtask

  task automatic test_full_frame;
    int d;
    run_frame(-1, 0, 0, -1, -1, 0, d);
    checks++;
    if (d != 4802) begin
      errors++;
      $display("FAIL full_frame_done_cycle got=%0d required=4802", d);
    end
  endtask

  task automatic test_backpressure;
    int d;
    run_frame(100, 5, 0, -1, -1, 0, d);
    checks++;
    if (d != 4807) begin
      errors++;
      $display("FAIL backpressure_done_cycle got=%0d required=4807", d);
    end
  endtask

  task automatic test_row_wrap_random;
    int d;
    run_frame(-1, 0, 1, -1, -1, 0, d);
    checks++;
    if (d < 4802) begin
      errors++;
      $display("FAIL random_ready_done_cycle got=%0d required>=4802", d);
    end
  endtask

  task automatic test_abort_restart;
    int d;
    run_frame(-1, 0, 0, 2000, -1, 0, d);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort busy=%b valid=%b required 0 0", o_busy, o_valid);
    end
    run_frame(-1, 0, 0, -1, -1, 0, d);
    checks++;
    if (d != 4802) begin
      errors++;
      $display("FAIL restart_done_cycle got=%0d required=4802", d);
    end
  endtask

  task automatic test_start_busy_and_reset;
    int d;
    run_frame(-1, 0, 0, -1, -1, 1, d);
    checks++;
    if (d != 4802) begin
      errors++;
      $display("FAIL start_while_busy_done_cycle got=%0d required=4802", d);
    end
    run_frame(-1, 0, 0, -1, 3000, 0, d);
    run_frame(-1, 0, 0, -1, -1, 0, d);
    checks++;
    if (d != 4802) begin
      errors++;
      $display("FAIL after_reset_done_cycle got=%0d required=4802", d);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_row_wrap_random();
    test_abort_restart();
    test_start_busy_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
